// File: rtl/fp_alu_pkg.sv
// Shared FP ALU types and constants: operand width, arbiter FSM states, canonical IEEE-754 encodings.
// No logic and no latency; nothing here carries a handshake.
package fp_alu_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Round-robin picker: first asserted req at or after ptr, wrapping; one-hot gnt plus its index.
// Combinational, zero latency; en low forces no grant, so the caller owns all backpressure.
module fp_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] k;
    int               j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      k = IDX_W'(j);
      if (en && !found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/fp_tree_multiplier.sv
// IEEE-754 single-precision multiply, round-to-nearest-even; subnormal inputs and results flush to signed zero.
// Purely combinational (no latency, no handshake); overflow flags a finite product that rounds past the largest normal.
module fp_tree_multiplier
  import fp_alu_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result,
  output logic            overflow
);

  logic        sign;
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic [23:0] sig;
  logic        guard, sticky, rnd;
  logic [24:0] rounded;
  logic [10:0] exp_n, exp_f;

  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);

    // Significand product left to synthesis, which maps it onto a partial-product reduction tree.
    prod  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_n = {3'b0, ea} + {3'b0, eb} - 11'd127 + {10'd0, prod[47]};

    if (prod[47]) begin
      sig    = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      sig    = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd     = guard & (sticky | sig[0]);
    rounded = {1'b0, sig} + {24'd0, rnd};
    exp_f   = exp_n + {10'd0, rounded[24]};

    // exp_f is two's complement; bit 10 set means the biased exponent went below zero.
    result   = '0;
    overflow = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      result = FP_QNAN;
    end else if (a_inf || b_inf) begin
      result = {sign, FP_POS_INF[30:0]};
    end else if (a_zero || b_zero || exp_f[10] || (exp_f == 11'd0)) begin
      result = {sign, 31'd0};
    end else if (exp_f >= 11'd255) begin
      result   = {sign, FP_POS_INF[30:0]};
      overflow = 1'b1;
    end else begin
      result = {sign, exp_f[7:0], rounded[24] ? rounded[23:1] : rounded[22:0]};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fp_tree_multiplier among N_REQ requesters via round-robin; 2 cycles from request handshake to rsp_valid.
// One op in flight: no req_ready outside IDLE, and RESP holds its outputs until the owner asserts rsp_ready.
module fp_mul_arbiter
  import fp_alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [FP_W-1:0]       rsp_result,
  output logic                  rsp_overflow,
  output logic                  busy
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [FP_W-1:0]  op_a, op_b;
  logic [FP_W-1:0]  res_q;
  logic             ovf_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             busy_q;

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [FP_W-1:0]  mul_result;
  logic             mul_ovf;

  // Gated by rst so no request can appear accepted during a reset cycle.
  fp_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      ((state == IDLE) && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  fp_tree_multiplier u_mul (
    .a        (op_a),
    .b        (op_b),
    .result   (mul_result),
    .overflow (mul_ovf)
  );

  assign req_ready    = gnt;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign busy         = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            op_a   <= req_a[FP_W*int'(gnt_idx) +: FP_W];
            op_b   <= req_b[FP_W*int'(gnt_idx) +: FP_W];
            owner  <= gnt_idx;
            ptr    <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          res_q       <= mul_result;
          ovf_q       <= mul_ovf;
          rsp_valid_q <= N_REQ'(1) << owner;
          state       <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response; other bits are don't-care.
          if (rsp_ready[owner]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with N_REQ=4: single ops, round-robin back-to-back, backpressure, reset mid-op.
module tb_fp_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_result;
  logic         rsp_overflow;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.N_REQ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 4'b0000;
    tick; tick;
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=00000000", rsp_result); end
    n_cmp++; if (rsp_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", rsp_overflow); end
    req_valid = 4'b0000; rst = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b0 || req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL idle_outputs busy=%b req_ready=%b rsp_valid=%b exp 0/0000/0000", busy, req_ready, rsp_valid);
    end
  endtask

  task automatic test_single_ops;
    int          ids [4];
    logic [31:0] va [4], vb [4], vr [4];
    logic        vo [4];
    logic [3:0]  oh;
    ids[0] = 0; va[0] = 32'h3F80_0000; vb[0] = 32'h4000_0000; vr[0] = 32'h4000_0000; vo[0] = 1'b0;
    ids[1] = 2; va[1] = 32'h4120_0000; vb[1] = 32'hC1A0_0000; vr[1] = 32'hC348_0000; vo[1] = 1'b0;
    ids[2] = 1; va[2] = 32'h7F7F_FFFF; vb[2] = 32'h4000_0000; vr[2] = 32'h7F80_0000; vo[2] = 1'b1;
    ids[3] = 3; va[3] = 32'hFF80_0000; vb[3] = 32'h4000_0000; vr[3] = 32'hFF80_0000; vo[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << ids[k];
      req_a[32*ids[k] +: 32] = va[k];
      req_b[32*ids[k] +: 32] = vb[k];
      req_valid = oh;
      #1;
      n_cmp++; if (req_ready !== oh) begin n_fail++; $display("FAIL single%0d_grant got=%b exp=%b", k, req_ready, oh); end
      tick;
      req_valid = 4'b0000;
      #1;
      n_cmp++; if (busy !== 1'b1 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL single%0d_calc busy=%b rsp_valid=%b req_ready=%b exp 1/0000/0000", k, busy, rsp_valid, req_ready);
      end
      tick;
      n_cmp++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL single%0d_rsp_valid got=%b exp=%b", k, rsp_valid, oh); end
      n_cmp++; if (rsp_result !== vr[k]) begin n_fail++; $display("FAIL single%0d_result got=%h exp=%h", k, rsp_result, vr[k]); end
      n_cmp++; if (rsp_overflow !== vo[k]) begin n_fail++; $display("FAIL single%0d_ovf got=%b exp=%b", k, rsp_overflow, vo[k]); end
      rsp_ready = oh;
      tick;
      rsp_ready = 4'b0000;
      n_cmp++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
        n_fail++; $display("FAIL single%0d_done busy=%b rsp_valid=%b exp 0/0000", k, busy, rsp_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] er [4];
    logic [3:0]  oh;
    int          g;
    rst = 1'b1; tick; rst = 1'b0;
    req_a = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    req_b = {4{32'h4000_0000}};
    er[0] = 32'h4000_0000; er[1] = 32'h4080_0000; er[2] = 32'h40C0_0000; er[3] = 32'h4100_0000;
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      g  = k % 4;
      oh = 4'b0001 << g;
      n_cmp++; if (req_ready !== oh) begin n_fail++; $display("FAIL b2b%0d_grant got=%b exp=%b", k, req_ready, oh); end
      tick;
      n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin
        n_fail++; $display("FAIL b2b%0d_calc req_ready=%b rsp_valid=%b exp 0000/0000", k, req_ready, rsp_valid);
      end
      tick;
      n_cmp++; if (rsp_valid !== oh || rsp_result !== er[g]) begin
        n_fail++; $display("FAIL b2b%0d_rsp rsp_valid=%b result=%h exp %b/%h", k, rsp_valid, rsp_result, oh, er[g]);
      end
      tick;
    end
    req_valid = 4'b0000; rsp_ready = 4'b0000;
    tick;
  endtask

  task automatic test_backpressure;
    req_a[127:96] = 32'h4040_0000; req_b[127:96] = 32'h4040_0000;
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant got=%b exp=1000", req_ready); end
    tick;
    req_valid = 4'b0010;
    rsp_ready = 4'b0111;
    tick;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (rsp_valid !== 4'b1000 || rsp_result !== 32'h4110_0000 || rsp_overflow !== 1'b0 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold%0d rsp_valid=%b result=%h ovf=%b req_ready=%b exp 1000/41100000/0/0000",
                           c, rsp_valid, rsp_result, rsp_overflow, req_ready);
      end
      tick;
    end
    rsp_ready = 4'b1111;
    tick;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release busy=%b rsp_valid=%b req_ready=%b exp 0/0000/0010", busy, rsp_valid, req_ready);
    end
    req_valid = 4'b0000; rsp_ready = 4'b0000;
    tick;
  endtask

  task automatic test_reset_mid;
    req_a[63:32] = 32'h4000_0000; req_b[63:32] = 32'h4000_0000;
    req_valid = 4'b0010; rsp_ready = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_grant got=%b exp=0010", req_ready); end
    tick;
    req_valid = 4'b0000;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_calc_busy got=%b exp=1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rmid_no_rsp%0d rsp_valid=%b busy=%b exp 0000/0", c, rsp_valid, busy);
      end
      tick;
    end
    req_a[31:0]   = 32'h4040_0000; req_b[31:0]   = 32'h3F80_0000;
    req_a[127:96] = 32'h4080_0000; req_b[127:96] = 32'h3F80_0000;
    req_valid = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr_reset got=%b exp=0001", req_ready); end
    tick;
    req_valid = 4'b1000;
    tick;
    n_cmp++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'h4040_0000) begin
      n_fail++; $display("FAIL rmid_rsp rsp_valid=%b result=%h exp 0001/40400000", rsp_valid, rsp_result);
    end
    tick;
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rmid_next_grant got=%b exp=1000", req_ready); end
    tick;
    req_valid = 4'b0000;
    tick;
    n_cmp++; if (rsp_valid !== 4'b1000 || rsp_result !== 32'h4080_0000) begin
      n_fail++; $display("FAIL rmid_rsp3 rsp_valid=%b result=%h exp 1000/40800000", rsp_valid, rsp_result);
    end
    tick;
    rsp_ready = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    test_reset;
    test_single_ops;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
